// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle.
// Groups the three handshakes around the LSU:
//   req_*  : core execute stage -> LSU request (valid/ready)
//   resp_* : LSU -> core response (valid/ready)
//   mem_*  : LSU -> data memory request (req/ready) and read return (rvalid)
// Modport slave is the LSU's view; modport master is the core+memory side.
interface load_store_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [4:0]            req_rd;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [4:0]            resp_rd;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_we;
  logic                  resp_misaligned;
  logic                  resp_illegal;
  logic                  resp_bus_err;

  logic                  mem_req;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  resp_ready, mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rd, resp_rdata, resp_we,
    output resp_misaligned, resp_illegal, resp_bus_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output resp_ready, mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rd, resp_rdata, resp_we,
    input  resp_misaligned, resp_illegal, resp_bus_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RISC-V load/store unit, one outstanding transaction.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   io    : load_store_unit_if.slave (request, response and data-memory buses)
// Flow: IDLE accepts a request and decodes it; illegal/misaligned requests go
// straight to RESP. Legal ones issue mem_req in REQ, loads then wait for
// mem_rvalid in WAIT_R. A shared counter bounds the time spent in REQ+WAIT_R
// and reports a bus error when it runs out. All outputs are registered.
module load_store_unit #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  io
);
  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned OffW = $clog2(BeW);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [1:0]      SizeMax = 2'(OffW);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [OffW-1:0]   off_q;

  logic              req_ready_q, resp_valid_q, resp_we_q;
  logic              resp_mis_q, resp_ill_q, resp_berr_q;
  logic [4:0]        resp_rd_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BeW-1:0]    mem_be_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Request decode
  logic [1:0]        size_in;
  logic              uns_in, illegal_in, mis_in;
  logic [OffW-1:0]   off_in;
  logic [BeW-1:0]    be_mask, be_in;
  logic [DATA_W-1:0] wdata_in;

  always_comb begin
    size_in    = io.req_funct3[1:0];
    uns_in     = io.req_funct3[2];
    off_in     = io.req_addr[OffW-1:0];
    illegal_in = (size_in > SizeMax) || (uns_in && size_in == SizeMax) ||
                 (io.req_we && uns_in);
    case (size_in)
      2'd0:    begin mis_in = 1'b0;              be_mask = BeW'(1);
                     wdata_in = {(DATA_W/8){io.req_wdata[7:0]}};   end
      2'd1:    begin mis_in = io.req_addr[0];    be_mask = BeW'(3);
                     wdata_in = {(DATA_W/16){io.req_wdata[15:0]}}; end
      2'd2:    begin mis_in = |io.req_addr[1:0]; be_mask = BeW'(15);
                     wdata_in = {(DATA_W/32){io.req_wdata[31:0]}}; end
      default: begin mis_in = |io.req_addr[2:0]; be_mask = {BeW{1'b1}};
                     wdata_in = io.req_wdata;                      end
    endcase
    be_in = be_mask << off_in;
  end

  // Load data extraction: shift the addressed lane down, then extend from its msb
  logic [DATA_W-1:0] shifted, ext;
  logic              msb;
  int                nbits;

  always_comb begin
    shifted = io.mem_rdata >> {off_q, 3'b000};
    nbits   = 8 << size_q;
    if (nbits > int'(DATA_W)) nbits = int'(DATA_W);
    msb = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i == nbits - 1) msb = shifted[i];
    end
    for (int i = 0; i < int'(DATA_W); i++) begin
      ext[i] = (i < nbits) ? shifted[i] : (msb & ~uns_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_mis_q   <= 1'b0;
      resp_ill_q   <= 1'b0;
      resp_berr_q  <= 1'b0;
      resp_rd_q    <= '0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_ready_q && io.req_valid) begin
            req_ready_q  <= 1'b0;
            size_q       <= size_in;
            uns_q        <= uns_in;
            off_q        <= off_in;
            resp_rd_q    <= io.req_rd;
            resp_we_q    <= io.req_we;
            resp_rdata_q <= '0;
            resp_berr_q  <= 1'b0;
            resp_ill_q   <= illegal_in;
            resp_mis_q   <= ~illegal_in & mis_in;  // illegal takes priority
            mem_we_q     <= io.req_we;
            mem_addr_q   <= {io.req_addr[ADDR_W-1:OffW], OffW'(0)};
            mem_be_q     <= io.req_we ? be_in : '0;
            mem_wdata_q  <= io.req_we ? wdata_in : '0;
            if (illegal_in || mis_in) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
            end else begin
              state_q   <= StReq;
              mem_req_q <= 1'b1;
              cnt_q     <= '0;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + CntW'(1);
          if (io.mem_ready) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= StWaitR;
            end
          end else if (cnt_q >= CntLast) begin
            mem_req_q    <= 1'b0;
            resp_berr_q  <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StWaitR: begin
          cnt_q <= cnt_q + CntW'(1);
          if (io.mem_rvalid) begin
            resp_rdata_q <= ext;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else if (cnt_q >= CntLast) begin
            resp_berr_q  <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (io.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign io.req_ready       = req_ready_q;
  assign io.resp_valid      = resp_valid_q;
  assign io.resp_rd         = resp_rd_q;
  assign io.resp_rdata      = resp_rdata_q;
  assign io.resp_we         = resp_we_q;
  assign io.resp_misaligned = resp_mis_q;
  assign io.resp_illegal    = resp_ill_q;
  assign io.resp_bus_err    = resp_berr_q;
  assign io.mem_req         = mem_req_q;
  assign io.mem_we          = mem_we_q;
  assign io.mem_addr        = mem_addr_q;
  assign io.mem_be          = mem_be_q;
  assign io.mem_wdata       = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit and a 64-bit instance (timeout 8) share
// one set of stimulus signals; sel picks which one is driven and observed.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset, sel;
  logic req_valid, req_we, resp_ready, mem_ready, mem_rvalid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;
  logic [4:0]  req_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_W(32), .ADDR_W(32)) io32 ();
  load_store_unit_if #(.DATA_W(64), .ADDR_W(32)) io64 ();

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut32 (
    .clk(clk), .reset(reset), .io(io32));
  load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut64 (
    .clk(clk), .reset(reset), .io(io64));

  assign io32.req_valid  = req_valid & ~sel;
  assign io32.req_we     = req_we;
  assign io32.req_funct3 = req_funct3;
  assign io32.req_addr   = req_addr;
  assign io32.req_wdata  = req_wdata[31:0];
  assign io32.req_rd     = req_rd;
  assign io32.resp_ready = resp_ready & ~sel;
  assign io32.mem_ready  = mem_ready & ~sel;
  assign io32.mem_rvalid = mem_rvalid & ~sel;
  assign io32.mem_rdata  = mem_rdata[31:0];
  assign io64.req_valid  = req_valid & sel;
  assign io64.req_we     = req_we;
  assign io64.req_funct3 = req_funct3;
  assign io64.req_addr   = req_addr;
  assign io64.req_wdata  = req_wdata;
  assign io64.req_rd     = req_rd;
  assign io64.resp_ready = resp_ready & sel;
  assign io64.mem_ready  = mem_ready & sel;
  assign io64.mem_rvalid = mem_rvalid & sel;
  assign io64.mem_rdata  = mem_rdata;

  logic o_req_ready, o_resp_valid, o_resp_we, o_mis, o_ill, o_berr, o_mem_req, o_mem_we;
  logic [4:0]  o_resp_rd;
  logic [63:0] o_rdata, o_mem_wdata, o_mem_be, o_mem_addr;
  assign o_req_ready  = sel ? io64.req_ready       : io32.req_ready;
  assign o_resp_valid = sel ? io64.resp_valid      : io32.resp_valid;
  assign o_resp_we    = sel ? io64.resp_we         : io32.resp_we;
  assign o_mis        = sel ? io64.resp_misaligned : io32.resp_misaligned;
  assign o_ill        = sel ? io64.resp_illegal    : io32.resp_illegal;
  assign o_berr       = sel ? io64.resp_bus_err    : io32.resp_bus_err;
  assign o_mem_req    = sel ? io64.mem_req         : io32.mem_req;
  assign o_mem_we     = sel ? io64.mem_we          : io32.mem_we;
  assign o_resp_rd    = sel ? io64.resp_rd         : io32.resp_rd;
  assign o_rdata      = sel ? io64.resp_rdata      : {32'b0, io32.resp_rdata};
  assign o_mem_wdata  = sel ? io64.mem_wdata       : {32'b0, io32.mem_wdata};
  assign o_mem_be     = sel ? {56'b0, io64.mem_be} : {60'b0, io32.mem_be};
  assign o_mem_addr   = sel ? {32'b0, io64.mem_addr} : {32'b0, io32.mem_addr};

  typedef struct packed {
    logic        ill;
    logic        mis;
    logic [63:0] addr;
    logic [63:0] be;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  // Reference model straight from the access rules, byte by byte.
  function automatic exp_t model(input bit w64, input bit we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] rdata_in);
    exp_t e;
    int bytes, nbytes, off;
    logic [63:0] mask, v, rdata;
    bytes  = w64 ? 8 : 4;
    nbytes = 1 << f3[1:0];
    off    = int'(addr % 32'(bytes));
    rdata  = w64 ? rdata_in : (rdata_in & 64'hFFFF_FFFF);
    e.ill  = (nbytes > bytes) || (f3[2] && nbytes == bytes) || (we && f3[2]);
    e.mis  = !e.ill && ((addr % 32'(nbytes)) != 0);
    e.addr = {32'b0, addr - 32'(off)};
    e.be   = we ? (((64'd1 << nbytes) - 64'd1) << off) : 64'd0;
    e.wdata = '0;
    if (we) for (int k = 0; k < bytes; k++) e.wdata[8*k +: 8] = wdata[8*(k % nbytes) +: 8];
    mask = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * nbytes)) - 64'd1);
    v = (rdata >> (8 * off)) & mask;
    if (!f3[2] && v[8*nbytes-1]) v = v | ~mask;
    if (!w64) v = v & 64'hFFFF_FFFF;
    e.rdata = (we || e.ill || e.mis) ? 64'd0 : v;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds resp_ready low for dly cycles, then completes the response.
  task automatic resp_done(input int dly, input logic [63:0] exp_rdata, input logic [4:0] exp_rd);
    for (int i = 0; i < dly; i++) begin
      tick();
      check("hold_valid", o_resp_valid, 1);
      check("hold_rdata", o_rdata, exp_rdata);
      check("hold_rd", o_resp_rd, exp_rd);
      check("hold_req_ready", o_req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_drop", o_resp_valid, 0);
    check("ready_after_resp", o_req_ready, 1);
  endtask

  task automatic accept(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [4:0] rd);
    int n = 0;
    while (!o_req_ready && n < 20) begin tick(); n++; end
    check("req_ready_idle", o_req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd;
    tick();
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [63:0] rdata, input logic [4:0] rd,
                     input int rdy_dly, input int rv_dly, input int resp_dly);
    exp_t e;
    e = model(sel, we, f3, addr, wdata, rdata);
    accept(we, f3, addr, wdata, rd);
    if (e.ill || e.mis) begin
      check("err_no_mem_req", o_mem_req, 0);
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        check("mem_req", o_mem_req, 1);
        check("mem_addr", o_mem_addr, e.addr);
        check("mem_we", o_mem_we, we);
        check("mem_be", o_mem_be, e.be);
        check("mem_wdata", o_mem_wdata, e.wdata);
        if (i == rdy_dly) mem_ready = 1'b1;
        tick();
      end
      mem_ready = 1'b0;
      if (!we) begin
        mem_rdata = ~rdata;
        for (int i = 0; i <= rv_dly; i++) begin
          check("wait_mem_req", o_mem_req, 0);
          check("wait_no_resp", o_resp_valid, 0);
          if (i == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
          tick();
        end
        mem_rvalid = 1'b0;
        mem_rdata = ~rdata;
      end
    end
    check("resp_valid", o_resp_valid, 1);
    check("resp_req_ready", o_req_ready, 0);
    check("resp_rd", o_resp_rd, rd);
    check("resp_we", o_resp_we, we);
    check("resp_illegal", o_ill, e.ill);
    check("resp_misaligned", o_mis, e.mis);
    check("resp_bus_err", o_berr, 0);
    check("resp_rdata", o_rdata, e.rdata);
    resp_done(resp_dly, e.rdata, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; sel = 1'b0;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    resp_ready = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    tick();
    check("rst_req_ready", o_req_ready, 0);
    check("rst_resp_valid", o_resp_valid, 0);
    check("rst_mem_req", o_mem_req, 0);
    check("rst_mem_be", o_mem_be, 0);
    sel = 1'b1; #1;
    check("rst64_req_ready", o_req_ready, 0);
    check("rst64_mem_addr", o_mem_addr, 0);
    sel = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("req_ready_after_rst", o_req_ready, 1);

    // Directed 32-bit cases
    txn(1'b1, 3'b000, 32'h103, 64'hA5, 64'h0, 5'd3, 0, 0, 0);          // SB
    txn(1'b0, 3'b000, 32'h102, 64'h0, 64'h12F03456, 5'd7, 1, 2, 0);    // LB
    txn(1'b0, 3'b100, 32'h102, 64'h0, 64'h12F03456, 5'd9, 0, 2, 5);    // LBU, long stall
    check("lbu_value_model", model(1'b0, 1'b0, 3'b100, 32'h102, 64'h0, 64'h12F03456).rdata,
          64'h0000_00F0);
    txn(1'b0, 3'b001, 32'h101, 64'h0, 64'h0, 5'd4, 0, 0, 0);           // LH misaligned
    txn(1'b0, 3'b011, 32'h101, 64'h0, 64'h0, 5'd5, 0, 0, 0);           // LD illegal at 32
    txn(1'b1, 3'b100, 32'h100, 64'h0, 64'h0, 5'd6, 0, 0, 0);           // store unsigned
    txn(1'b0, 3'b110, 32'h100, 64'h0, 64'h0, 5'd8, 0, 0, 0);           // LWU illegal at 32

    // Timeout: mem_ready never comes
    accept(1'b1, 3'b010, 32'h200, 64'h1234_5678, 5'd2);
    n = 0;
    while (o_mem_req && n < 20) begin n++; tick(); end
    check("timeout_mem_req_cycles", 64'(n), 8);
    check("timeout_resp_valid", o_resp_valid, 1);
    check("timeout_bus_err", o_berr, 1);
    check("timeout_rdata", o_rdata, 0);
    resp_done(0, 64'd0, 5'd2);
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check("idle_rvalid_no_resp", o_resp_valid, 0);
    check("idle_rvalid_rdata", o_rdata, 0);

    // Asynchronous reset while waiting for read data
    accept(1'b0, 3'b010, 32'h40, 64'h0, 5'd11);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("waitr_mem_req", o_mem_req, 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_mem_addr", o_mem_addr, 0);
    check("async_rst_resp_rd", o_resp_rd, 0);
    check("async_rst_req_ready", o_req_ready, 0);
    #1 reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    check("post_rst_rvalid_ignored", o_resp_valid, 0);
    check("post_rst_req_ready", o_req_ready, 1);

    // Directed 64-bit cases
    sel = 1'b1;
    #1;
    txn(1'b0, 3'b110, 32'h14, 64'h0, 64'h89AB_CDEF_0000_0000, 5'd12, 0, 1, 0); // LWU
    txn(1'b0, 3'b011, 32'h18, 64'h0, 64'h8000_0000_0000_0001, 5'd13, 2, 0, 1); // LD
    txn(1'b1, 3'b001, 32'h16, 64'hBEEF, 64'h0, 5'd14, 1, 0, 0);               // SH
    txn(1'b0, 3'b111, 32'h10, 64'h0, 64'h0, 5'd15, 0, 0, 0);                  // illegal

    // Randomized traffic on both widths
    for (int t = 0; t < 160; t++) begin
      logic [31:0] a;
      int rdy;
      sel = t[0];
      #1;
      a = 32'h1000 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) a = a & ~32'h7;
      rdy = $urandom_range(0, 3);
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom},
          {$urandom, $urandom}, 5'($urandom), rdy, $urandom_range(0, 5 - rdy),
          $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised multi-cycle load/store unit between the core's execute stage and the data memory.
- Accepts one RISC-V load/store request per transaction with a valid/ready handshake.
- Generates aligned memory address, byte enables and lane-replicated store data.
- Extracts and sign/zero-extends load data, flags misaligned/illegal accesses, and times out stalled memory transactions.
- Single outstanding transaction. Successor to the combinational load/store decode, adding handshakes, wait states, width generality and error reporting.

Parameters:
- DATA_W, 32, data path width; 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT_R before bus error; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3: [1:0] size (0 B, 1 H, 2 W, 3 D), [2] unsigned (loads only)
- req_addr  in  ADDR_W  effective byte address (rs1+imm)
- req_wdata  in  DATA_W  store source (rs2 value)
- req_rd  in  5  load destination register
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rd  out  5  captured rd
- resp_rdata  out  DATA_W  extended load data; 0 for stores/errors
- resp_we  out  1  captured req_we
- resp_misaligned  out  1  address not size-aligned
- resp_illegal  out  1  unsupported funct3 for DATA_W
- resp_bus_err  out  1  memory timeout
- mem_req  out  1  memory request
- mem_ready  in  1  memory accepts request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word-aligned address (low log2(DATA_W/8) bits 0)
- mem_be  out  DATA_W/8  byte enables (stores only; 0 on loads)
- mem_wdata  out  DATA_W  replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data

Behaviour:
Reset: all outputs 0, state IDLE, timeout counter 0. Takes effect immediately (asynchronous), including mid-transaction. mem_req drops at once.

FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we/funct3/addr/wdata/rd.
  - Illegal or misaligned → RESP next cycle with the flag set; no mem_req.
  - Otherwise → REQ.
- REQ:
  - mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata held stable until mem_ready.
  - mem_ready=1: store → RESP; load → WAIT_R.
- WAIT_R:
  - mem_req=0.
  - On mem_rvalid, latch extended data → RESP.
  - mem_rvalid is only sampled in WAIT_R and ignored in all other states; earliest useful rvalid is the cycle after the mem_ready handshake.
- RESP:
  - resp_valid=1; all resp_* fields held stable until resp_ready.
  - Then IDLE, with req_ready=1 the following cycle.

Best-case latency:
- Store: accept N, mem_req N+1 (ready same cycle), resp_valid N+2.
- Load: resp_valid one cycle after mem_rvalid.
- Error: resp_valid N+1.

Illegal encodings:
- size > log2(DATA_W/8).
- Unsigned with size = log2(DATA_W/8) (e.g. funct3 110 at DATA_W=32, 111 at 64).
- Store with funct3[2]=1.
- Illegal has priority over misaligned; only one flag is set.

Misaligned: addr mod (1<<size) ≠ 0.

Byte enables: ((1<<(1<<size))-1) << offset, where offset = addr mod (DATA_W/8).

Store data: rs2 low (8<<size) bits replicated across all DATA_W bits.

Load data: (mem_rdata >> 8·offset), low (8<<size) bits, then sign-extended (funct3[2]=0) or zero-extended to DATA_W.

Timeout:
- Counter increments each cycle in REQ or WAIT_R.
- On reaching TIMEOUT_CYCLES without the awaited handshake: mem_req deasserts, go to RESP with resp_bus_err=1, resp_rdata=0.
- Counter clears on entering REQ.

Test Plan:
- DATA_W=32, SB addr 0x103, wdata 0x000000A5, mem_ready=1 → mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1; resp_valid 2 cycles after accept, flags 0.
- LB addr 0x102, mem_rdata=0x12F03456 with rvalid 3 cycles after ready → resp_rdata=0xFFFFFFF0; repeated with LBU → 0x000000F0; resp_rd matches req_rd.
- LH addr 0x101 → no mem_req ever; resp_valid next cycle with resp_misaligned=1, rdata 0. funct3=011 at DATA_W=32 → resp_illegal=1, misaligned=0.
- TIMEOUT_CYCLES=8, mem_ready held 0 → mem_req high exactly 8 cycles, then resp_bus_err=1. A later mem_rvalid in IDLE has no effect.
- resp_ready held 0 for 5 cycles → resp_* stable and req_ready=0 throughout; next request accepted one cycle after resp_ready.
- reset pulsed while in WAIT_R → all outputs 0 without a clock edge; subsequent mem_rvalid is ignored. DATA_W=64: LWU addr 0x14, rdata 0x89ABCDEF_00000000 → rdata 0x0000000089ABCDEF.
